alu_exec_stage: RTL

//  Execute-stage wrapper around the 4-bit ALU: accepts a register-form instruction
//  (oc, rd, rs1, rs2) via valid/ready, reads operands from an internal register file,

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/cpu_regfile.sv | 45 ++++
 rtl/alu_exec_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the execute stage: default widths, opcode encoding
// and the stage FSM state type.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned NREGS_DEF  = 4;
  localparam int unsigned OC_W_DEF   = 3;

  // ALU opcode encoding (3-bit, matches the external ALU)
  localparam logic [2:0] OC_ADD = 3'd0;
  localparam logic [2:0] OC_SUB = 3'd1;
  localparam logic [2:0] OC_MUL = 3'd2;
  localparam logic [2:0] OC_DIV = 3'd3;
  localparam logic [2:0] OC_NOT = 3'd4;
  localparam logic [2:0] OC_XOR = 3'd5;
  localparam logic [2:0] OC_OR  = 3'd6;
  localparam logic [2:0] OC_AND = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_regfile.sv
// Register file: NREGS x DATA_W, two asynchronous read ports, one synchronous
// write port, synchronous active-high clear.
//   clk, rst           clock / synchronous reset (clears every entry)
//   raddr_a_i/rdata_a_o read port A
//   raddr_b_i/rdata_b_o read port B
//   we_i, waddr_i, wdata_i  write port
// Indices at or beyond NREGS read as zero and drop writes.
module cpu_regfile #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned IDX_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [IDX_W-1:0]  raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] mem_q [NREGS];

  // Asynchronous reads with out-of-range guard
  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if (32'(raddr_a_i) < NREGS) rdata_a_o = mem_q[raddr_a_i];
    if (32'(raddr_b_i) < NREGS) rdata_b_o = mem_q[raddr_b_i];
  end

  // Synchronous write / clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (32'(waddr_i) < NREGS)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage around an external combinational ALU. Accepts a register-form
// instruction over valid/ready, snapshots operands from the internal register
// file, drives the ALU for one cycle, writes the result back to rd and
// presents result/flags downstream over valid/ready.
//   clk, rst                 clock / synchronous active-high reset
//   in_valid/in_ready        instruction handshake (in_oc, in_rd, in_rs1, in_rs2)
//   ld_en/ld_addr/ld_data    external register load, honoured in IDLE only
//   alu_oc/alu_a/alu_b       registered drive to the ALU; alu_f its result
//   out_valid/out_ready      result handshake (out_result, out_rd, flag_z, flag_dz)
module alu_exec_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned OC_W   = OC_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OC_W-1:0]           in_oc,
  input  logic [$clog2(NREGS)-1:0]  in_rd,
  input  logic [$clog2(NREGS)-1:0]  in_rs1,
  input  logic [$clog2(NREGS)-1:0]  in_rs2,
  input  logic                      ld_en,
  input  logic [$clog2(NREGS)-1:0]  ld_addr,
  input  logic [DATA_W-1:0]         ld_data,
  output logic [OC_W-1:0]           alu_oc,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic [DATA_W-1:0]         alu_f,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_result,
  output logic [$clog2(NREGS)-1:0]  out_rd,
  output logic                      flag_z,
  output logic                      flag_dz
);

  localparam int unsigned IDX_W = $clog2(NREGS);

  state_e            state_q, state_d;
  logic [OC_W-1:0]   oc_q, oc_d;
  logic [IDX_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [IDX_W-1:0]  out_rd_q, out_rd_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_dz_q, flag_dz_d;

  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b;
  logic              rf_we;
  logic [IDX_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  cpu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr_a_i (in_rs1),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (in_rs2),
    .rdata_b_o (rf_rdata_b),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata)
  );

  assign in_ready = (state_q == ST_IDLE) && !rst;

  // Write-port mux: ALU writeback in EXEC, external load only while IDLE
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if (state_q == ST_EXEC) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = alu_f;
    end else if ((state_q == ST_IDLE) && ld_en) begin
      rf_we    = 1'b1;
    end
  end

  // Next-state and latch updates
  always_comb begin
    state_d      = state_q;
    oc_d         = oc_q;
    rd_d         = rd_q;
    a_d          = a_q;
    b_d          = b_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    flag_z_d     = flag_z_q;
    flag_dz_d    = flag_dz_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          // Operand snapshot uses pre-load register values
          oc_d    = in_oc;
          rd_d    = in_rd;
          a_d     = rf_rdata_a;
          b_d     = rf_rdata_b;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        out_result_d = alu_f;
        out_rd_d     = rd_q;
        flag_z_d     = (alu_f == '0);
        flag_dz_d    = (oc_q == OC_W'(OC_DIV)) && (b_q == '0);
        out_valid_d  = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      oc_q         <= '0;
      rd_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      flag_z_q     <= 1'b0;
      flag_dz_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      oc_q         <= oc_d;
      rd_q         <= rd_d;
      a_q          <= a_d;
      b_q          <= b_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      flag_z_q     <= flag_z_d;
      flag_dz_q    <= flag_dz_d;
    end
  end

  assign alu_oc     = oc_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_rd     = out_rd_q;
  assign flag_z     = flag_z_q;
  assign flag_dz    = flag_dz_q;

endmodule
